// File: rtl/cmp_pkg.sv
// Shared state and result encodings for the sequential magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Result bit order is {lt, gt, eq}
  localparam logic [2:0] RES_LT   = 3'b100;
  localparam logic [2:0] RES_GT   = 3'b010;
  localparam logic [2:0] RES_EQ   = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

endpackage

// File: rtl/digit_cmp_rom.sv
// 16-entry lookup comparing one 2-bit digit pair; address is {b[1:0], a[1:0]}.
module digit_cmp_rom
  import cmp_pkg::*;
(
  input  logic [3:0] addr,
  output logic [2:0] data
);

  always_comb begin
    data = RES_NONE;
    case (addr)
      4'b00_00: data = RES_EQ;
      4'b00_01: data = RES_GT;
      4'b00_10: data = RES_GT;
      4'b00_11: data = RES_GT;
      4'b01_00: data = RES_LT;
      4'b01_01: data = RES_EQ;
      4'b01_10: data = RES_GT;
      4'b01_11: data = RES_GT;
      4'b10_00: data = RES_LT;
      4'b10_01: data = RES_LT;
      4'b10_10: data = RES_EQ;
      4'b10_11: data = RES_GT;
      4'b11_00: data = RES_LT;
      4'b11_01: data = RES_LT;
      4'b11_10: data = RES_LT;
      4'b11_11: data = RES_EQ;
      default:  data = RES_NONE;
    endcase
  end

endmodule

// File: rtl/seq_mag_compare.sv
// Multi-cycle MSB-first magnitude comparator scanning one 2-bit digit pair per clock.
// Define SEQ_MAG_COMPARE_SIGNED_EN for two's-complement operands.
module seq_mag_compare
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             Lt,
  output logic             Gt,
  output logic             Eq
);

  localparam int DIGITS = WIDTH / 2;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS - 1);

  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("seq_mag_compare: WIDTH must be even and >= 2");
    end
  endgenerate

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       result;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [1:0]       a_dig;
  logic [1:0]       b_dig;
  logic [2:0]       rom_data;

`ifdef SEQ_MAG_COMPARE_SIGNED_EN
  // Flipping the sign bit maps two's complement onto offset binary, so the unsigned scan still orders correctly.
  localparam logic [WIDTH-1:0] SIGN_FLIP = {1'b1, {(WIDTH-1){1'b0}}};
  assign a_in = a ^ SIGN_FLIP;
  assign b_in = b ^ SIGN_FLIP;
`else
  assign a_in = a;
  assign b_in = b;
`endif

  assign a_dig = a_q[{idx, 1'b0} +: 2];
  assign b_dig = b_q[{idx, 1'b0} +: 2];

  digit_cmp_rom u_rom (
    .addr ({b_dig, a_dig}),
    .data (rom_data)
  );

  assign {Lt, Gt, Eq} = result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= RES_NONE;
      idx    <= IDX_TOP;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q   <= a_in;
            b_q   <= b_in;
            idx   <= IDX_TOP;
            state <= ST_COMPARE;
            busy  <= 1'b1;
          end
        end
        ST_COMPARE: begin
          // Keep scanning only while digits match and lower digits remain.
          if ((rom_data == RES_EQ) && (idx != '0)) begin
            idx <= idx - 1'b1;
          end else begin
            result <= rom_data;
            state  <= ST_DONE;
            done   <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
